// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_types (package)
// Description : Shared types for the instruction-fetch front end: the fetch
//               FSM state encoding and the {pc, instruction} queue entry.
// Contents    : rv32i_word    - 32-bit machine word
//               fetch_state_t - S_IDLE / S_REQ / S_DISCARD
//               fq_entry_t    - packed {pc, instr} pair held in the queue
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,   // no request outstanding
        S_REQ     = 2'd1,   // request outstanding, response will be kept
        S_DISCARD = 2'd2    // request outstanding, response will be dropped
    } fetch_state_t;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fq_fifo
// Description : DEPTH-entry circular queue with synchronous flush. The head
//               entry is presented combinationally from storage.
// Ports       : clk, rst (async, active-low)
//               push/push_data - enqueue one entry (ignored when full)
//               pop            - dequeue the head entry (ignored when empty)
//               flush          - empty the queue; wins over push and pop
//               full, empty, count, head - occupancy and head entry
// Revision    : 1.0 - initial release
// ============================================================================
module fq_fifo
    import fetch_types::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fq_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output T                           head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_invalid
        $error("fq_fifo: DEPTH must be a power of two and at least 2");
    end

    T              r_mem [DEPTH];
    logic [PW-1:0] r_head_ptr;
    logic [PW-1:0] r_tail_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == c_full_count);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_head_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Pointers are exactly log2(DEPTH) bits, so they wrap without compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_tail_ptr] <= push_data;
                r_tail_ptr        <= r_tail_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_head_ptr <= r_head_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The fetch side reserves a slot before issuing, so a push into a full
    // queue means the reservation logic is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && full && !flush));

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Decoupled instruction-fetch front end. Owns the fetch PC,
//               issues single-outstanding icache reads into a DEPTH-entry
//               {pc, instr} queue drained by decode, and handles redirects,
//               including dropping a response already in flight.
// Ports       : clk, rst (async, active-low)
//               redirect_valid/redirect_pc - taken branch / jump target
//               icache_read/icache_addr    - registered read request
//               icache_rdata/icache_resp   - one-cycle response
//               deq_valid/deq_ready        - decode handshake
//               deq_pc/deq_instr           - head entry
//               count                      - queue occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_types::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0060
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       icache_read,
    output logic [XLEN-1:0]            icache_addr,
    input  logic [XLEN-1:0]            icache_rdata,
    input  logic                       icache_resp,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [XLEN-1:0]            deq_pc,
    output logic [XLEN-1:0]            deq_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   c_depth_m1 = CW'(DEPTH - 1);
    localparam logic [XLEN-1:0] c_pc_step  = XLEN'(4);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_pending_pc;
    logic            r_icache_read;
    logic [XLEN-1:0] r_icache_addr;

    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] w_fetch_pc_inc;
    logic [XLEN-1:0] w_discard_target;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_after_pop;
    logic            w_room_idle;
    logic            w_room_after_push;
    fq_entry_t       w_push_entry;
    fq_entry_t       w_head;

    assign w_redirect_pc    = {redirect_pc[XLEN-1:1], 1'b0};
    assign w_fetch_pc_inc   = r_fetch_pc + c_pc_step;
    // Latest redirect wins, even when it lands on the discarded response.
    assign w_discard_target = redirect_valid ? w_redirect_pc : r_pending_pc;

    assign w_pop   = ~w_empty & deq_ready;
    assign w_flush = redirect_valid;
    // A response that coincides with a redirect belongs to the old path.
    assign w_push  = (r_state == S_REQ) & icache_resp & ~redirect_valid;

    // Slot reservation: a new request only goes out if the queue, after this
    // cycle's pop and push, still has room for the response it will bring.
    assign w_count_after_pop = w_count - {{(CW-1){1'b0}}, w_pop};
    assign w_room_idle       = ~w_full | w_pop;
    assign w_room_after_push = (w_count_after_pop < c_depth_m1);

    assign w_push_entry = '{pc: r_fetch_pc, instr: icache_rdata};

    fq_fifo #(
        .DEPTH (DEPTH),
        .T     (fq_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (w_flush),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count),
        .head      (w_head)
    );

    // Fetch FSM. icache_read/icache_addr are registered here so the request
    // address can never glitch while a read is outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_pending_pc  <= RESET_PC;
            r_icache_read <= 1'b0;
            r_icache_addr <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        r_fetch_pc    <= w_redirect_pc;
                        r_icache_addr <= w_redirect_pc;
                        r_icache_read <= 1'b1;
                        r_state       <= S_REQ;
                    end else if (w_room_idle) begin
                        r_icache_addr <= r_fetch_pc;
                        r_icache_read <= 1'b1;
                        r_state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (icache_resp) begin
                        if (redirect_valid) begin
                            r_fetch_pc    <= w_redirect_pc;
                            r_icache_addr <= w_redirect_pc;
                        end else begin
                            r_fetch_pc <= w_fetch_pc_inc;
                            if (w_room_after_push) begin
                                r_icache_addr <= w_fetch_pc_inc;
                            end else begin
                                r_icache_read <= 1'b0;
                                r_state       <= S_IDLE;
                            end
                        end
                    end else if (redirect_valid) begin
                        // The issued address must stay put until its
                        // response arrives; remember where to go next.
                        r_pending_pc <= w_redirect_pc;
                        r_state      <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (icache_resp) begin
                        r_fetch_pc    <= w_discard_target;
                        r_icache_addr <= w_discard_target;
                        r_state       <= S_REQ;
                    end else if (redirect_valid) begin
                        r_pending_pc <= w_redirect_pc;
                    end
                end
                default: begin
                    r_icache_read <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign icache_read = r_icache_read;
    assign icache_addr = r_icache_addr;
    assign deq_valid   = ~w_empty;
    assign deq_pc      = w_head.pc;
    assign deq_instr   = w_head.instr;
    assign count       = w_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. Directed scenarios for
//               reset, throughput, back-pressure and redirect corner cases,
//               followed by randomized traffic checked against a
//               transaction-level reference (expected next fetch target plus
//               a queue of {pc, instr} entries).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk            = 1'b0;
    logic            rst            = 1'b1;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc    = '0;
    logic            icache_read;
    logic [XLEN-1:0] icache_addr;
    logic [XLEN-1:0] icache_rdata   = '0;
    logic            icache_resp    = 1'b0;
    logic            deq_valid;
    logic            deq_ready      = 1'b0;
    logic [XLEN-1:0] deq_pc;
    logic [XLEN-1:0] deq_instr;
    logic [CW-1:0]   count;

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0060)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .icache_read    (icache_read),
        .icache_addr    (icache_addr),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_pc         (deq_pc),
        .deq_instr      (deq_instr),
        .count          (count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    int          n_vec = 0;
    int          n_err = 0;

    // Reference state: what decode should see, where the next fresh request
    // must point, and whether the outstanding request was overtaken.
    ent_t        m_q[$];
    logic [31:0] m_next_pc;
    logic [31:0] m_req_addr;
    bit          m_out;
    bit          m_stale;
    int          m_idle;
    int          m_cyc;
    logic [31:0] m_start_addr[$];
    int          m_start_cyc[$];

    int          p_rdy, p_rsp, p_rv;
    bit          s_rv, s_rdy, s_rsp;
    logic [31:0] s_rpc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_next_pc = 32'h60;
        m_out     = 1'b0;
        m_stale   = 1'b0;
        m_idle    = 0;
        m_start_addr.delete();
        m_start_cyc.delete();
    endtask

    task automatic check_state();
        chk("count", 32'(count), 32'(m_q.size()));
        chk("deq_valid", 32'(deq_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("deq_pc", deq_pc, m_q[0].pc);
            chk("deq_instr", deq_instr, m_q[0].instr);
        end
        if (icache_read) begin
            m_idle = 0;
            if (!m_out) begin
                chk("req_addr", icache_addr, m_next_pc);
                chk("req_slot", 32'(icache_read), 32'(m_q.size() < DEPTH));
                m_out      = 1'b1;
                m_stale    = 1'b0;
                m_req_addr = icache_addr;
                m_start_addr.push_back(icache_addr);
                m_start_cyc.push_back(m_cyc);
            end else begin
                chk("addr_stable", icache_addr, m_req_addr);
            end
        end else begin
            if (m_out) begin
                chk("read_held", 32'(icache_read), 32'd1);
                m_out = 1'b0;
            end
            if (m_q.size() < DEPTH) begin
                m_idle++;
                if (m_idle > 1) chk("fetch_stall", 32'(icache_read), 32'd1);
            end else begin
                m_idle = 0;
            end
        end
    endtask

    task automatic model_step(input bit rv, input logic [31:0] rpc, input bit rdy,
                              input bit rsp, input logic [31:0] rdata);
        ent_t e;
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (rsp && m_out) begin
            if (!rv && !m_stale) begin
                e.pc    = m_req_addr;
                e.instr = rdata;
                m_q.push_back(e);
                m_next_pc = m_req_addr + 32'd4;
            end
            m_out = 1'b0;
        end
        if (rv) begin
            m_q.delete();
            m_next_pc = rpc & 32'hFFFF_FFFE;
            if (m_out) m_stale = 1'b1;
        end
        m_cyc++;
    endtask

    // One clock: check at the falling edge, drive inputs, advance the model
    // on the rising edge. rsp only answers an outstanding read; stray
    // injects a response regardless.
    task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy,
                         input bit rsp, input bit stray);
        logic [31:0] d;
        bit          r;
        @(negedge clk);
        check_state();
        d = $urandom();
        r = (rsp && icache_read) || stray;
        redirect_valid = rv;
        redirect_pc    = rpc;
        deq_ready      = rdy;
        icache_rdata   = d;
        icache_resp    = r;
        @(posedge clk);
        model_step(rv, rpc, rdy, r, d);
    endtask

    // Asynchronous reset landing between clock edges; optionally a late
    // icache response right at release, which must be ignored.
    task automatic do_reset(input bit stray);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_read", 32'(icache_read), 32'd0);
        chk("rst_addr", icache_addr, 32'h60);
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("rst_deq_pc", deq_pc, 32'd0);
        chk("rst_deq_instr", deq_instr, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        redirect_valid = 1'b0;
        icache_resp    = 1'b0;
        deq_ready      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst          = 1'b1;
        icache_resp  = stray;
        icache_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
    endtask

    initial begin
        m_cyc = 0;
        model_reset();

        // Streaming: one request per cycle starting at the reset PC.
        do_reset(1'b0);
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("t1_nreq", 32'(m_start_addr.size()), 32'd6);
        if (m_start_addr.size() >= 3) begin
            chk("t1_addr0", m_start_addr[0], 32'h60);
            chk("t1_addr1", m_start_addr[1], 32'h64);
            chk("t1_addr2", m_start_addr[2], 32'h68);
            chk("t1_rate", 32'(m_start_cyc[2] - m_start_cyc[0]), 32'd2);
        end

        // Back-pressure: exactly DEPTH fetches, then resume after a pop.
        do_reset(1'b0);
        repeat (8) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("t2_count", 32'(count), 32'd4);
        chk("t2_read", 32'(icache_read), 32'd0);
        chk("t2_nreq", 32'(m_start_addr.size()), 32'd4);
        if (m_start_addr.size() == 4) chk("t2_last", m_start_addr[3], 32'h6C);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("t2_nreq_resume", 32'(m_start_addr.size()), 32'd5);
        if (m_start_addr.size() == 5) chk("t2_resume", m_start_addr[4], 32'h70);

        // Redirect while 0x68 is pending: address held, data dropped.
        do_reset(1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
        #1 chk("t3_hold0", icache_addr, 32'h68);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1 chk("t3_hold1", icache_addr, 32'h68);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1 chk("t3_hold2", icache_addr, 32'h68);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("t3_count", 32'(count), 32'd0);
        chk("t3_next", icache_addr, 32'h200);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Redirect together with the response for 0x64.
        do_reset(1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
        #1;
        chk("t4_addr", icache_addr, 32'h300);
        chk("t4_read", 32'(icache_read), 32'd1);
        chk("t4_count", 32'(count), 32'd0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Two redirects inside one discard window: the latest wins.
        do_reset(1'b0);
        cycle(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        #1 chk("t5_addr", icache_addr, 32'h500);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset mid-request with two entries queued, late response after.
        do_reset(1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t6_queued", 32'(count), 32'd2);
        chk("t6_pending", 32'(icache_read), 32'd1);
        do_reset(1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("t6_nreq", 32'(m_start_addr.size()), 32'd1);
        if (m_start_addr.size() == 1) chk("t6_first", m_start_addr[0], 32'h60);

        // Randomized traffic with varying pressure, including targets near
        // the top of the address space so the PC wraps.
        do_reset(1'b0);
        for (int blk = 0; blk < 20; blk++) begin
            p_rdy = $urandom_range(10, 100);
            p_rsp = $urandom_range(20, 100);
            p_rv  = $urandom_range(0, 15);
            for (int i = 0; i < 150; i++) begin
                s_rv  = ($urandom_range(0, 99) < p_rv);
                s_rdy = ($urandom_range(0, 99) < p_rdy);
                s_rsp = ($urandom_range(0, 99) < p_rsp);
                s_rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                                    : $urandom();
                cycle(s_rv, s_rpc, s_rdy, s_rsp, 1'b0);
            end
            if (blk == 10) do_reset(1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end. Replaces the fixed "icache_read always high, PC+4" fetch with a decoupled prefetch buffer.
- Owns the fetch PC and issues single-outstanding icache reads.
- Buffers {pc, instruction} pairs in a DEPTH-entry queue; decode drains the queue through a valid/ready handshake.
- Handles branch/jump redirects, including discarding a response that is already in flight.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 32'h00000060, fetch PC after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  EX/MEM resolved a taken branch, jal or jalr.
- redirect_pc  in  XLEN  new fetch target; bit 0 is ignored and forced to 0.
- icache_read  out  1  read request; held until icache_resp.
- icache_addr  out  XLEN  request address; stable while icache_read=1.
- icache_rdata  in  XLEN  instruction word; valid when icache_resp=1.
- icache_resp  in  1  one-cycle response pulse.
- deq_valid  out  1  head entry available.
- deq_ready  in  1  decode accepts the head entry (ifid_load).
- deq_pc  out  XLEN  PC of the head entry.
- deq_instr  out  XLEN  instruction of the head entry.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst=0, async):
  - state=S_IDLE, fetch_pc=RESET_PC, pending_pc=RESET_PC.
  - Head/tail pointers 0, count=0.
  - icache_read=0, icache_addr=RESET_PC, deq_valid=0, deq_pc=0, deq_instr=0.
  - Reset asserted mid-request drops the request; a late icache_resp after reset release is ignored while in S_IDLE.
- States:
  - S_IDLE: icache_read=0.
  - S_REQ: icache_read=1, icache_addr=fetch_pc.
  - S_DISCARD: icache_read=1, icache_addr=the address already issued. Its response is dropped.
- Slot reservation: a request may be issued only if count + inflight < DEPTH. inflight=1 in S_REQ/S_DISCARD. Overflow is therefore impossible; an overflow assertion fires if push occurs with count==DEPTH.
- S_IDLE -> S_REQ when a slot is free and redirect_valid=0. icache_addr is registered, so a request is visible one cycle after the decision.
- S_REQ, icache_resp=1, no redirect:
  - Push {fetch_pc, icache_rdata}; fetch_pc += 4 (mod 2^XLEN, wraps).
  - Next state is S_REQ if a slot remains after this cycle's push/pop, else S_IDLE.
  - Throughput: one instruction per cycle when icache responds every cycle and the queue is not full.
- S_REQ, icache_resp=0, redirect_valid=1:
  - Flush the queue; pending_pc=redirect_pc.
  - Go to S_DISCARD. icache_addr must not change mid-request.
- S_REQ, icache_resp=1, redirect_valid=1: do not push; flush; fetch_pc=redirect_pc; go to S_REQ.
- S_IDLE, redirect_valid=1: flush; fetch_pc=redirect_pc; go to S_REQ.
- S_DISCARD:
  - On icache_resp: drop the data, fetch_pc=pending_pc, go to S_REQ.
  - A further redirect overwrites pending_pc (latest wins).
  - Redirect and resp in the same cycle: use the new redirect_pc.
- Dequeue:
  - deq_valid = (count != 0); deq_pc/deq_instr show the head entry combinationally from storage.
  - Pop on deq_valid & deq_ready.
- Push and pop in the same cycle leave count unchanged.
- Pop and redirect in the same cycle: flush wins, count=0. The consumer discards via its own branch flush.
- Pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Package fetch_types:
  - fetch_state_t enum {S_IDLE, S_REQ, S_DISCARD}.
  - fq_entry_t struct {rv32i_word pc; rv32i_word instr}.
- Sub-module fq_fifo (params DEPTH, entry type):
  - Ports: push, pop, flush, full, empty, count, head.
  - Asynchronous active-low reset; flush has priority over push/pop.
- FSM and PC logic stay in fetch_queue.

Test Plan:
- Reset release with icache_resp every cycle, deq_ready=1:
  - icache_addr sequence 0x60, 0x64, 0x68.
  - deq_pc follows one cycle behind the pushes, with one instruction per cycle.
- deq_ready=0, DEPTH=4, resp each cycle:
  - Exactly 4 pushes (0x60–0x6C); icache_read drops to 0 with count=4.
  - Raising deq_ready resumes fetch at 0x70.
- Redirect to 0x200 while request 0x68 is pending (resp delayed 3 cycles):
  - icache_addr stays 0x68 until resp; data dropped; count=0.
  - Next request is 0x200.
- Redirect to 0x300 in the same cycle as resp for 0x64: 0x64 is not enqueued; next icache_addr=0x300; queue empty.
- Two redirects (0x400, then 0x500) during one S_DISCARD window: next request is 0x500.
- rst=0 asserted mid-request with 2 queued entries:
  - All outputs go to reset values immediately.
  - After release, first request is 0x60.
